// File: rtl/sd_emmc_cmd_responder_pkg.sv
// ---------------------------------------------------------------------------
// sd_emmc_cmd_responder_pkg
// Shared definitions for the device-side eMMC CMD-line responder.
// Contents:
//   - response-type encodings (RSP_NONE, RSP_R2, RSP_R1, RSP_R3)
//   - command / long-response frame lengths (48, 136)
//   - CRC7 polynomial (x^7 + x^3 + 1 -> 7'h09) and a one-bit step helper
//   - FSM state encodings
// ---------------------------------------------------------------------------
package sd_emmc_cmd_responder_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'b00,
        RSP_R2   = 2'b01,
        RSP_R1   = 2'b10,
        RSP_R3   = 2'b11
    } rsp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_WAIT,
        ST_TX
    } state_e;

    localparam int         CMD_FRAME_LEN = 48;
    localparam int         R2_FRAME_LEN  = 136;
    localparam logic [6:0] CRC7_POLY     = 7'h09;

    // One serial CRC7 step, MSB-first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_emmc_crc7.sv
// ---------------------------------------------------------------------------
// sd_emmc_crc7
// Serial CRC7 (x^7 + x^3 + 1) accumulator, one bit per sd_clk.
// Ports:
//   sd_clk  in   card clock
//   rst_n   in   async reset, active-low
//   clr     in   restart the CRC; combined with en, the first bit is folded in
//   en      in   fold bit_i into the CRC this cycle
//   bit_i   in   serial data bit
//   crc_o   out  current CRC remainder
// ---------------------------------------------------------------------------
module sd_emmc_crc7
    import sd_emmc_cmd_responder_pkg::*;
(
    input  logic       sd_clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_o <= 7'h00;
        end else if (en) begin
            crc_o <= crc7_step(clr ? 7'h00 : crc_o, bit_i);
        end else if (clr) begin
            crc_o <= 7'h00;
        end
    end

endmodule

// File: rtl/sd_emmc_cmd_responder.sv
// ---------------------------------------------------------------------------
// sd_emmc_cmd_responder
// Device-side eMMC CMD-line endpoint: receives 48-bit host commands (framing
// and CRC7 checked) and transmits R1/R3 (48-bit) or R2 (136-bit) responses.
// Ports:
//   sd_clk, rst_n                     clock, async active-low reset
//   cmd_i / cmd_o / cmd_oe_o          CMD pad sample, drive value, enable
//   cmd_valid_o, cmd_index_o,
//   cmd_arg_o, cmd_crc_err_o          received-command interface
//   rsp_start_i, rsp_type_i,
//   rsp_index_i, rsp_data_i           response request from emulation logic
//   rsp_done_o, rsp_timeout_o         response completion / NCR expiry pulses
//   busy_o                            FSM not in IDLE
//   cmd_count_o, crc_err_count_o      statistics (saturating)
// Build option: define SD_EMMC_CMD_RSP_STATS_EN to build the statistics
// counters; otherwise those ports read as zero.
// ---------------------------------------------------------------------------
module sd_emmc_cmd_responder
    import sd_emmc_cmd_responder_pkg::*;
#(
    parameter int NCR_MIN = 2,
    parameter int NCR_MAX = 64
) (
    input  logic         sd_clk,
    input  logic         rst_n,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_oe_o,
    output logic         cmd_valid_o,
    output logic [5:0]   cmd_index_o,
    output logic [31:0]  cmd_arg_o,
    output logic         cmd_crc_err_o,
    input  logic         rsp_start_i,
    input  logic [1:0]   rsp_type_i,
    input  logic [5:0]   rsp_index_i,
    input  logic [127:0] rsp_data_i,
    output logic         rsp_done_o,
    output logic         rsp_timeout_o,
    output logic         busy_o,
    output logic [15:0]  cmd_count_o,
    output logic [15:0]  crc_err_count_o
);

    state_e         state;
    logic [7:0]     bit_cnt;      // index of the frame bit on the line (RX and TX)
    logic [46:0]    rx_sr;        // received bits 46..0 (start bit is implied)
    logic [135:0]   tx_sr;        // response frame, right-aligned
    logic [6:0]     ncr_cnt;
    logic           rsp_latched;
    rsp_type_e      rsp_type_q;
    logic [5:0]     rsp_index_q;
    logic [127:0]   rsp_data_q;

    logic           crc_clr, crc_en, crc_bit;
    logic [6:0]     crc;

    // One CRC engine serves both directions; the line is never RX and TX at once.
    sd_emmc_crc7 u_crc7 (
        .sd_clk (sd_clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_i  (crc_bit),
        .crc_o  (crc)
    );

    // Response request: a fresh assertion in WAIT uses the live inputs, a
    // latched one uses the values captured when it first arrived.
    logic       start_now, go_tx;
    rsp_type_e  sel_type;
    logic [5:0] sel_index;
    logic [127:0] sel_data;
    logic [135:0] tx_frame;
    logic [7:0] tx_next_idx;
    logic [2:0] crc_sel;
    logic       tx_next_bit, in_crc_field;

    assign start_now   = (state == ST_WAIT) && rsp_start_i && !rsp_latched;
    assign sel_type    = start_now ? rsp_type_e'(rsp_type_i) : rsp_type_q;
    assign sel_index   = start_now ? rsp_index_i : rsp_index_q;
    assign sel_data    = start_now ? rsp_data_i  : rsp_data_q;
    assign go_tx       = (state == ST_WAIT) && (rsp_latched || start_now) &&
                         (ncr_cnt >= 7'(NCR_MIN));

    assign tx_next_idx  = bit_cnt - 8'd1;
    assign tx_next_bit  = tx_sr[tx_next_idx];
    assign crc_sel      = tx_next_idx[2:0] - 3'd1;
    // R3 carries a fixed 7'h7F in the CRC slot, already present in tx_sr.
    assign in_crc_field = (tx_next_idx >= 8'd1) && (tx_next_idx <= 8'd7) &&
                          (rsp_type_q != RSP_R3);

    assign busy_o = (state != ST_IDLE);

    always_comb begin
        tx_frame = '0;
        case (sel_type)
            RSP_R2:  tx_frame = {2'b00, 6'h3F, sel_data[127:8], 7'h00, 1'b1};
            RSP_R1:  tx_frame = {88'h0, 2'b00, sel_index, sel_data[31:0], 7'h00, 1'b1};
            RSP_R3:  tx_frame = {88'h0, 2'b00, 6'h3F, sel_data[31:0], 7'h7F, 1'b1};
            default: tx_frame = '0;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_bit = cmd_i;
        case (state)
            ST_IDLE: begin
                crc_clr = !cmd_i;
                crc_en  = !cmd_i;
            end
            ST_RX: crc_en = (bit_cnt >= 8'd8);
            ST_WAIT: begin
                // R1 CRC covers the start bit launched on this edge; R2 CRC
                // covers the payload only.
                crc_clr = go_tx;
                crc_en  = go_tx && (sel_type == RSP_R1);
                crc_bit = 1'b0;
            end
            ST_TX: begin
                crc_bit = tx_next_bit;
                crc_en  = (bit_cnt != 8'd0) && (tx_next_idx >= 8'd8) &&
                          ((rsp_type_q == RSP_R1) ||
                           ((rsp_type_q == RSP_R2) && (tx_next_idx <= 8'd127)));
            end
            default: ;
        endcase
    end

    // NOTE: the wide capture registers are reset along with the control state
    // so nothing undefined can ever be shifted onto the pad.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= 8'd0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            ncr_cnt       <= 7'd0;
            rsp_latched   <= 1'b0;
            rsp_type_q    <= RSP_NONE;
            rsp_index_q   <= 6'd0;
            rsp_data_q    <= '0;
            cmd_o         <= 1'b1;
            cmd_oe_o      <= 1'b0;
            cmd_valid_o   <= 1'b0;
            cmd_crc_err_o <= 1'b0;
            cmd_index_o   <= 6'd0;
            cmd_arg_o     <= 32'd0;
            rsp_done_o    <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            cmd_valid_o   <= 1'b0;
            cmd_crc_err_o <= 1'b0;
            rsp_done_o    <= 1'b0;
            rsp_timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!cmd_i) begin
                        state   <= ST_RX;
                        bit_cnt <= 8'd46;
                        rx_sr   <= '0;
                    end
                end
                ST_RX: begin
                    rx_sr <= {rx_sr[45:0], cmd_i};
                    if (bit_cnt == 8'd0) state   <= ST_CHECK;
                    else                 bit_cnt <= bit_cnt - 8'd1;
                end
                ST_CHECK: begin
                    if (!rx_sr[46]) begin
                        state <= ST_IDLE;          // another device's response
                    end else if (!rx_sr[0] || (rx_sr[7:1] != crc)) begin
                        cmd_crc_err_o <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        cmd_valid_o <= 1'b1;
                        cmd_index_o <= rx_sr[45:40];
                        cmd_arg_o   <= rx_sr[39:8];
                        ncr_cnt     <= 7'd1;
                        rsp_latched <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (start_now) begin
                        rsp_latched <= 1'b1;
                        rsp_type_q  <= rsp_type_e'(rsp_type_i);
                        rsp_index_q <= rsp_index_i;
                        rsp_data_q  <= rsp_data_i;
                    end
                    if (go_tx) begin
                        if (sel_type == RSP_NONE) begin
                            state <= ST_IDLE;
                        end else begin
                            rsp_type_q <= sel_type;
                            tx_sr      <= tx_frame;
                            bit_cnt    <= (sel_type == RSP_R2) ? 8'(R2_FRAME_LEN - 1)
                                                               : 8'(CMD_FRAME_LEN - 1);
                            cmd_o      <= 1'b0;    // start bit
                            cmd_oe_o   <= 1'b1;
                            state      <= ST_TX;
                        end
                    end else if (ncr_cnt >= 7'(NCR_MAX)) begin
                        rsp_timeout_o <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        ncr_cnt <= ncr_cnt + 7'd1;
                    end
                end
                ST_TX: begin
                    if (bit_cnt == 8'd0) begin
                        cmd_o      <= 1'b1;
                        cmd_oe_o   <= 1'b0;
                        rsp_done_o <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        bit_cnt <= tx_next_idx;
                        cmd_o   <= in_crc_field ? crc[crc_sel] : tx_next_bit;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SD_EMMC_CMD_RSP_STATS_EN
    logic [15:0] cmd_count_q, crc_err_count_q;

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_count_q     <= 16'h0;
            crc_err_count_q <= 16'h0;
        end else begin
            if (cmd_valid_o && (cmd_count_q != 16'hFFFF))
                cmd_count_q <= cmd_count_q + 16'd1;
            if (cmd_crc_err_o && (crc_err_count_q != 16'hFFFF))
                crc_err_count_q <= crc_err_count_q + 16'd1;
        end
    end

    assign cmd_count_o     = cmd_count_q;
    assign crc_err_count_o = crc_err_count_q;
`else
    assign cmd_count_o     = 16'h0;
    assign crc_err_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_sd_emmc_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_sd_emmc_cmd_responder
// Self-checking bench: a table of command frames with expected receive
// results, followed by hand-written response, timeout and reset sequences.
// Inputs change on the falling edge; outputs are read on the falling edge.
// ---------------------------------------------------------------------------
module tb_sd_emmc_cmd_responder;

`ifdef SD_EMMC_CMD_RSP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         sd_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_i = 1'b1;
    logic         rsp_start_i = 1'b0;
    logic [1:0]   rsp_type_i = 2'b00;
    logic [5:0]   rsp_index_i = 6'd0;
    logic [127:0] rsp_data_i = '0;
    logic         cmd_o, cmd_oe_o, cmd_valid_o, cmd_crc_err_o;
    logic [5:0]   cmd_index_o;
    logic [31:0]  cmd_arg_o;
    logic         rsp_done_o, rsp_timeout_o, busy_o;
    logic [15:0]  cmd_count_o, crc_err_count_o;

    sd_emmc_cmd_responder #(.NCR_MIN(2), .NCR_MAX(64)) dut (
        .sd_clk          (sd_clk),
        .rst_n           (rst_n),
        .cmd_i           (cmd_i),
        .cmd_o           (cmd_o),
        .cmd_oe_o        (cmd_oe_o),
        .cmd_valid_o     (cmd_valid_o),
        .cmd_index_o     (cmd_index_o),
        .cmd_arg_o       (cmd_arg_o),
        .cmd_crc_err_o   (cmd_crc_err_o),
        .rsp_start_i     (rsp_start_i),
        .rsp_type_i      (rsp_type_i),
        .rsp_index_i     (rsp_index_i),
        .rsp_data_i      (rsp_data_i),
        .rsp_done_o      (rsp_done_o),
        .rsp_timeout_o   (rsp_timeout_o),
        .busy_o          (busy_o),
        .cmd_count_o     (cmd_count_o),
        .crc_err_count_o (crc_err_count_o)
    );

    always #5 sd_clk = ~sd_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e_cyc = 0;           // posedge count at the edge sampling the end bit
    int exp_good = 0;
    int exp_err = 0;

    // Line monitor: counts driven cycles, captures driven bits, logs pulses.
    int           oe_cycles = 0;
    logic [135:0] rsp_bits = '0;
    logic         oe_prev = 1'b0;
    int           start_cyc = -1;
    int           done_cnt = 0;
    int           timeout_cnt = 0;
    int           timeout_cyc = -1;

    always @(posedge sd_clk) cyc <= cyc + 1;

    always @(negedge sd_clk) begin
        if (cmd_oe_o) begin
            oe_cycles = oe_cycles + 1;
            rsp_bits  = {rsp_bits[134:0], cmd_o};
            if (!oe_prev) start_cyc = cyc;
        end
        oe_prev = cmd_oe_o;
        if (rsp_done_o) done_cnt = done_cnt + 1;
        if (rsp_timeout_o) begin
            timeout_cnt = timeout_cnt + 1;
            timeout_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] d, input int n);
        logic [6:0] c;
        logic fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7({96'h0, h}, 40), 1'b1};
    endfunction

    // Drive a 48-bit frame MSB first; returns on the falling edge after the
    // rising edge that sampled the end bit, with the line released high.
    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            cmd_i = f[i];
        end
        @(negedge sd_clk);
        cmd_i = 1'b1;
        e_cyc = cyc;
    endtask

    task automatic wait_done(input int base, input string name);
        int n;
        n = 0;
        while (done_cnt == base && n < 400) begin
            @(negedge sd_clk);
            n++;
        end
        check(name, 136'(done_cnt != base), 136'(1));
    endtask

    task automatic wait_negedges(input int n);
        for (int i = 0; i < n; i++) @(negedge sd_clk);
    endtask

    typedef struct {
        logic [47:0] frame;
        logic        exp_valid;
        logic        exp_err;
        logic [5:0]  exp_index;
        logic [31:0] exp_arg;
    } vec_t;

    vec_t         vecs [8];
    logic [47:0]  f;
    logic [47:0]  mask;
    logic [39:0]  h1;
    logic [127:0] r2_data;
    logic [135:0] exp_frame;
    int           base;

    initial begin
        mask = 48'h1 << 46;
        vecs[0] = '{48'h400000000095, 1'b1, 1'b0, 6'd0, 32'h0};
        vecs[1] = '{48'h48000001AA87, 1'b1, 1'b0, 6'd8, 32'h000001AA};
        vecs[2] = '{48'h400000000097, 1'b0, 1'b1, 6'd8, 32'h000001AA};
        vecs[3] = '{make_cmd(6'd17, 32'hDEADBEEF), 1'b1, 1'b0, 6'd17, 32'hDEADBEEF};
        vecs[4] = '{make_cmd(6'd63, 32'hFFFFFFFF), 1'b1, 1'b0, 6'd63, 32'hFFFFFFFF};
        vecs[5] = '{make_cmd(6'd17, 32'hDEADBEEF) & ~48'h1, 1'b0, 1'b1, 6'd63, 32'hFFFFFFFF};
        vecs[6] = '{make_cmd(6'd2, 32'h0) & ~mask, 1'b0, 1'b0, 6'd63, 32'hFFFFFFFF};
        vecs[7] = '{make_cmd(6'd55, 32'h0) ^ (48'h1 << 8), 1'b0, 1'b1, 6'd63, 32'hFFFFFFFF};

        // ---------------- reset state ----------------
        #12;
        check("reset cmd_o", 136'(cmd_o), 136'(1));
        check("reset cmd_oe_o", 136'(cmd_oe_o), 136'(0));
        check("reset pulses", 136'({cmd_valid_o, cmd_crc_err_o, rsp_done_o, rsp_timeout_o, busy_o}), 136'(0));
        check("reset index/arg", 136'({cmd_index_o, cmd_arg_o}), 136'(0));
        check("reset counters", 136'({cmd_count_o, crc_err_count_o}), 136'(0));
        @(negedge sd_clk);
        rst_n = 1'b1;
        wait_negedges(2);

        // ---------------- receive table ----------------
        oe_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].frame);
            @(negedge sd_clk);
            check($sformatf("vec%0d cmd_valid_o", i), 136'(cmd_valid_o), 136'(vecs[i].exp_valid));
            check($sformatf("vec%0d cmd_crc_err_o", i), 136'(cmd_crc_err_o), 136'(vecs[i].exp_err));
            check($sformatf("vec%0d index", i), 136'(cmd_index_o), 136'(vecs[i].exp_index));
            check($sformatf("vec%0d arg", i), 136'(cmd_arg_o), 136'(vecs[i].exp_arg));
            if (vecs[i].exp_valid) exp_good++;
            if (vecs[i].exp_err) exp_err++;
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d busy in WAIT", i), 136'(busy_o), 136'(1));
                // Type 00 response: returns to IDLE without touching the line.
                rsp_start_i = 1'b1;
                rsp_type_i  = 2'b00;
                @(negedge sd_clk);
                rsp_start_i = 1'b0;
                check($sformatf("vec%0d valid one cycle", i), 136'(cmd_valid_o), 136'(0));
                wait_negedges(2);
            end
            check($sformatf("vec%0d idle", i), 136'(busy_o), 136'(0));
            @(negedge sd_clk);
        end
        check("table line never driven", 136'(oe_cycles), 136'(0));
        check("crc_err_count_o", 136'(crc_err_count_o), 136'(STATS ? exp_err : 0));

        // ---------------- CMD8 + R1, start sampled 5 edges after end bit ----------------
        oe_cycles = 0;
        base = done_cnt;
        send_frame(48'h48000001AA87);
        exp_good++;
        wait_negedges(4);
        rsp_start_i = 1'b1;
        rsp_type_i  = 2'b10;
        rsp_index_i = 6'd8;
        rsp_data_i  = 128'h000001AA;
        @(negedge sd_clk);
        rsp_start_i = 1'b0;
        rsp_index_i = 6'd0;
        rsp_data_i  = '0;
        wait_done(base, "R1 rsp_done_o");
        h1 = {2'b00, 6'd8, 32'h000001AA};
        exp_frame = 136'({h1, crc7({96'h0, h1}, 40), 1'b1});
        check("R1 start latency", 136'(start_cyc - e_cyc), 136'(5));
        check("R1 oe cycles", 136'(oe_cycles), 136'(48));
        check("R1 frame", 136'(rsp_bits[47:0]), exp_frame);
        check("R1 line released", 136'({cmd_oe_o, cmd_o, busy_o}), 136'(3'b010));

        // ---------------- CMD2 + R2, inputs scrambled after the start pulse ----------------
        oe_cycles = 0;
        base = done_cnt;
        r2_data = 128'h1501004D41473247410A1234ABCDC800;
        send_frame(make_cmd(6'd2, 32'h0));
        exp_good++;
        @(negedge sd_clk);
        rsp_start_i = 1'b1;
        rsp_type_i  = 2'b01;
        rsp_data_i  = r2_data;
        @(negedge sd_clk);
        rsp_start_i = 1'b0;
        rsp_type_i  = 2'b11;
        rsp_data_i  = ~r2_data;
        wait_done(base, "R2 rsp_done_o");
        exp_frame = {2'b00, 6'h3F, r2_data[127:8], crc7({16'h0, r2_data[127:8]}, 120), 1'b1};
        check("R2 start latency", 136'(start_cyc - e_cyc), 136'(3));
        check("R2 oe cycles", 136'(oe_cycles), 136'(136));
        check("R2 frame", rsp_bits, exp_frame);
        rsp_type_i = 2'b00;
        rsp_data_i = '0;

        // ---------------- CMD13 with no response: NCR timeout ----------------
        oe_cycles = 0;
        base = timeout_cnt;
        send_frame(make_cmd(6'd13, 32'h00010000));
        exp_good++;
        for (int n = 0; n < 100 && timeout_cnt == base; n++) @(negedge sd_clk);
        check("timeout pulse seen", 136'(timeout_cnt - base), 136'(1));
        // Counter is 1 on the second edge after the end bit, reaches 64 on the 65th.
        check("timeout edge", 136'(timeout_cyc - e_cyc), 136'(65));
        while (cyc < e_cyc + 69) @(negedge sd_clk);
        rsp_start_i = 1'b1;
        rsp_type_i  = 2'b10;
        @(negedge sd_clk);
        rsp_start_i = 1'b0;
        rsp_type_i  = 2'b00;
        wait_negedges(5);
        check("late start ignored", 136'({oe_cycles, busy_o}), 136'(0));
        check("single timeout", 136'(timeout_cnt - base), 136'(1));
        check("cmd_count_o", 136'(cmd_count_o), 136'(STATS ? exp_good : 0));

        // ---------------- reset in the middle of an R1 transmission ----------------
        base = done_cnt;
        send_frame(48'h400000000095);
        @(negedge sd_clk);
        rsp_start_i = 1'b1;
        rsp_type_i  = 2'b10;
        rsp_data_i  = 128'hA5A55A5A;
        @(negedge sd_clk);
        rsp_start_i = 1'b0;
        // Start bit launched 3 edges after the end bit; bit 20 launched 27 later.
        while (cyc < e_cyc + 30) @(negedge sd_clk);
        check("oe high at bit 20", 136'(cmd_oe_o), 136'(1));
        rst_n = 1'b0;
        #1;
        check("async release oe", 136'(cmd_oe_o), 136'(0));
        check("async release cmd_o", 136'(cmd_o), 136'(1));
        check("async reset busy", 136'(busy_o), 136'(0));
        @(negedge sd_clk);
        rst_n = 1'b1;
        check("no done after abort", 136'(done_cnt - base), 136'(0));
        exp_good = 0;
        exp_err  = 0;
        send_frame(48'h400000000095);
        exp_good++;
        @(negedge sd_clk);
        check("post-reset cmd_valid_o", 136'(cmd_valid_o), 136'(1));
        check("post-reset index/arg", 136'({cmd_index_o, cmd_arg_o}), 136'(0));
        rsp_start_i = 1'b1;
        rsp_type_i  = 2'b00;
        @(negedge sd_clk);
        rsp_start_i = 1'b0;
        wait_negedges(3);
        check("post-reset counters", 136'({cmd_count_o, crc_err_count_o}),
              136'({16'(STATS ? exp_good : 0), 16'(0)}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
